multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode from the instruction register and sequences every instruction through fetch, decode, execute, memory and writeback. Produces all datapath enables and muxes, plus the 2-bit `alu_op` class code consumed by the ALU control decoder (00 add, 01 sub, 10 funct-directed). Handshakes with a variable-latency memory through `mem_ready`.

---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and waits on a variable-latency memory.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Unconditional per-state controls; pc_write here covers JUMP only, the
  // fetch PC update is qualified by mem_ready below.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       done;
  } ctrl_t;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  always_comb begin
    next_state = state;
    case (state)
      RST:    next_state = FETCH;
      FETCH:  if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) next_state = MEMWB;
      MEMWR:  if (mem_ready) next_state = FETCH;
      EXEC:   next_state = ALUWB;
      ADDIEX: next_state = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Outputs are registered alongside the state by decoding the next state,
  // so they change on the same edge as state_o and clear with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
      ctrl  <= '0;
    end else begin
      state <= next_state;
      ctrl  <= decode_state(next_state);
    end
  end

  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state_o    = state;

  assign ir_write   = (state == FETCH) && mem_ready;
  assign pc_en      = ctrl.pc_write | ir_write | (ctrl.branch & zero);
  assign instr_done = ctrl.done | ((state == MEMWR) && mem_ready);
  assign illegal_op = (state == DECODE) && !is_legal(opcode);

endmodule
